mac_accum: RTL

Downstream accumulation stage for the pipelined 8x8 multiplier. It consumes the 16-bit product stream and sums each group of N_TERMS consecutive products into one dot-product result. Results are delivered through a one-entry output register with a valid/ready handshake. While a finished result waits to be taken, the next group keeps accumulating; input back-pressure is applied only when a second group completes before the first result is consumed.

---
 rtl/mac_accum.sv | 117 +++++++++++
 1 files changed

// File: rtl/mac_accum.sv
// Purpose : sums each group of N_TERMS unsigned 16-bit products into one ACC_W-bit result with a sticky overflow flag.
// Latency : out_valid rises one cycle after the accept of a group's last term; one term per cycle sustained.
// Backpr. : in_ready drops only on a group's last term while the previous result is still held and out_ready is low.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     product handshake, in_prod = 16-bit unsigned product
//   out_valid/out_ready   result handshake, out_sum = group sum, out_ovf = overflow seen in the group
//
// Build option: ACC_SAT_EN -- when defined, an add that carries out clamps the
// accumulator to all-ones for the rest of the group; otherwise sums wrap.
module mac_accum #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int                CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TERMS - 1);
`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic             last_term;
    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   add_w;
    logic [ACC_W-1:0] term_acc;
    logic             term_ovf;

    always_comb begin
        last_term = (cnt_q == LAST_CNT);
        // Only the last term of a group needs the output slot, so only it can stall.
        in_ready  = !(last_term && out_valid_q && !out_ready);
        accept    = in_valid && in_ready;

        prod_ext  = ACC_W'(in_prod);
        add_w     = {1'b0, acc_q} + {1'b0, prod_ext};

        // Value the accumulator takes if this term is accepted; the first term
        // of a group restarts the sum instead of adding to the previous group.
        if (cnt_q == '0) begin
            term_acc = prod_ext;
            term_ovf = 1'b0;
        end else begin
            term_ovf = ovf_q | add_w[ACC_W];
`ifdef ACC_SAT_EN
            // Folding in ovf_q keeps the accumulator pinned once it has clamped.
            term_acc = term_ovf ? ACC_MAX : add_w[ACC_W-1:0];
`else
            term_acc = add_w[ACC_W-1:0];
`endif
        end

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            acc_d = term_acc;
            ovf_d = term_ovf;
            cnt_d = last_term ? '0 : cnt_q + CNT_W'(1);
        end

        // A completing group wins over a drain in the same cycle: the new
        // result replaces the one being consumed and out_valid stays high.
        if (accept && last_term) begin
            out_valid_d = 1'b1;
            out_sum_d   = term_acc;
            out_ovf_d   = term_ovf;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule
